// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request issuer: opcodes, data width,
// FSM state encodings and the buffered request record.
`timescale 1ns/1ps
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_LE  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;

    // Issuer FSM states, kept as plain constants so older code can compare raw codes
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

    // True for opcodes the external ALU actually implements
    function automatic logic is_supported(input logic [3:0] op);
        return (op == OP_LE) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO for the issuer. Push is refused when full even if a pop
// happens in the same cycle, so the full flag never depends on the pop.
`timescale 1ns/1ps
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  alu_req_t               push_data,
    input  logic                   pop,
    output alu_req_t               pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    alu_req_t   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic push_ok;
    logic pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_req_issuer.sv
// Accepts ALU requests into a FIFO, drives them one at a time to an external
// combinational ALU and returns each result on a ready/valid response channel.
// Unsupported opcodes skip the ALU and answer directly with an error flag.
`timescale 1ns/1ps
module alu_req_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_opcode,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_opcode,
    output logic              rsp_err
);

    state_t   state;
    alu_req_t fifo_in;
    alu_req_t fifo_head;
    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    // Ready is held low during reset so nothing is taken while the FIFO is cleared
    assign req_ready = rst_n && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_in   = '{opcode: req_opcode, a: req_a, b: req_b};

    // Empty flag and zero count must agree before a head entry is trusted
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && (fifo_count != '0);

    assign rsp_valid = (state == ST_RESP);

    alu_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Issue FSM: pop in IDLE, sample the ALU in ISSUE, hold the response in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_opcode <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        if (is_supported(fifo_head.opcode)) begin
                            alu_opcode <= fifo_head.opcode;
                            alu_a      <= fifo_head.a;
                            alu_b      <= fifo_head.b;
                            state      <= ST_ISSUE;
                        end else begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                            rsp_opcode <= fifo_head.opcode;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    rsp_result <= alu_result;
                    rsp_err    <= 1'b0;
                    rsp_opcode <= alu_opcode;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
